// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: request/grant handshake plus the read-return path.
// The requester uses the master modport and the arbiter uses the slave modport.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a single-port RAM. The current owner may take a bounded
// burst before it must yield, and registered RAM read data is routed back to the port that read.
module ram_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      a_if,
    ram_arbiter_if.slave      b_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
    localparam logic       PortA    = 1'b0;
    localparam logic       PortB    = 1'b1;

    state_e     state_q;
    logic       last_q;
    logic [3:0] cnt_q;
    logic       rd_pend_q;
    logic       rd_own_q;

    logic win_a;
    logic win_b;
    logic yield;

    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        // >= also covers a count that saturated past the limit while the other side was idle
        yield = (cnt_q >= MaxBurst);
        if (a_if.req && b_if.req) begin
            unique case (state_q)
                StOwnA: begin
                    win_a = ~yield;
                    win_b = yield;
                end
                StOwnB: begin
                    win_b = ~yield;
                    win_a = yield;
                end
                default: begin
                    win_a = (last_q == PortB);
                    win_b = (last_q == PortA);
                end
            endcase
        end else begin
            win_a = a_if.req;
            win_b = b_if.req;
        end
    end

    assign a_if.gnt = win_a & ~rst;
    assign b_if.gnt = win_b & ~rst;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (a_if.gnt) begin
            mem_addr  = a_if.addr;
            mem_wdata = a_if.wdata;
            mem_we    = a_if.we;
        end else if (b_if.gnt) begin
            mem_addr  = b_if.addr;
            mem_wdata = b_if.wdata;
            mem_we    = b_if.we;
        end
    end

    assign a_if.rvalid = rd_pend_q & (rd_own_q == PortA);
    assign b_if.rvalid = rd_pend_q & (rd_own_q == PortB);
    assign a_if.rdata  = a_if.rvalid ? mem_rdata : '0;
    assign b_if.rdata  = b_if.rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= PortB;
            cnt_q     <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= PortA;
        end else begin
            rd_pend_q <= (win_a & ~a_if.we) | (win_b & ~b_if.we);
            if ((win_a & ~a_if.we) | (win_b & ~b_if.we)) begin
                rd_own_q <= win_b ? PortB : PortA;
            end
            if (!win_a && !win_b) begin
                state_q <= StIdle;
                cnt_q   <= 4'd0;
            end else if ((state_q == StOwnA && win_a) || (state_q == StOwnB && win_b)) begin
                cnt_q <= (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                state_q <= win_a ? StOwnA : StOwnB;
                cnt_q   <= 4'd1;
                last_q  <= win_a ? PortA : PortB;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a reference model predicts grants and RAM drive each
// cycle and queues expected read returns, which a separate monitor checks.
module tb_ram_arbiter;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_if     (a_if),
        .b_if     (b_if),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    // RAM with registered read, as the arbiter expects
    logic [7:0] ram    [256];
    logic [7:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'(i) ^ 8'hE0;
            shadow[i] = 8'(i) ^ 8'hE0;
        end
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: owner 0=none 1=A 2=B, run = grants in the current ownership
    int owner = 0;
    int run = 0;
    int last = 2;
    int wait_a = 0;
    int wait_b = 0;

    always @(negedge clk) begin : model
        int   ew;
        logic ereq_we;
        logic [7:0] eaddr, ewdata;
        if (rst) begin
            owner = 0; run = 0; last = 2; wait_a = 0; wait_b = 0;
            chk("rst_a_gnt", 32'(a_if.gnt), 0);
            chk("rst_b_gnt", 32'(b_if.gnt), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
        end else begin
            if (a_if.req && b_if.req) begin
                if (owner == 0) ew = (last == 1) ? 2 : 1;
                else if (run < int'(MB)) ew = owner;
                else ew = 3 - owner;
            end else if (a_if.req) ew = 1;
            else if (b_if.req) ew = 2;
            else ew = 0;

            ereq_we = 1'b0; eaddr = 8'h00; ewdata = 8'h00;
            if (ew == 1) begin ereq_we = a_if.we; eaddr = a_if.addr; ewdata = a_if.wdata; end
            if (ew == 2) begin ereq_we = b_if.we; eaddr = b_if.addr; ewdata = b_if.wdata; end

            chk("a_gnt", 32'(a_if.gnt), 32'(ew == 1));
            chk("b_gnt", 32'(b_if.gnt), 32'(ew == 2));
            chk("mem_we", 32'(mem_we), 32'(ereq_we));
            chk("mem_addr", 32'(mem_addr), 32'(eaddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(ewdata));

            wait_a = (a_if.req && ew != 1) ? wait_a + 1 : 0;
            wait_b = (b_if.req && ew != 2) ? wait_b + 1 : 0;
            if (a_if.req) chk("a_wait_bound", 32'(wait_a <= int'(MB)), 1);
            if (b_if.req) chk("b_wait_bound", 32'(wait_b <= int'(MB)), 1);

            if (ew != 0) begin
                if (ereq_we) shadow[eaddr] = ewdata;
                else exp_q.push_back('{port: ew, data: shadow[eaddr]});
            end

            if (ew == 0) begin
                owner = 0; run = 0;
            end else if (ew == owner) begin
                run = (run < 15) ? run + 1 : 15;
            end else begin
                owner = ew; run = 1; last = ew;
            end
        end
    end

    // Monitor: everything queued was accepted at the previous negedge, so it is due now
    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (rst) begin
            exp_q.delete();
            chk("rst_a_rvalid", 32'(a_if.rvalid), 0);
            chk("rst_b_rvalid", 32'(b_if.rvalid), 0);
            chk("rst_a_rdata", 32'(a_if.rdata), 0);
            chk("rst_b_rdata", 32'(b_if.rdata), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_rvalid", 32'(a_if.rvalid), 32'(e.port == 1));
            chk("b_rvalid", 32'(b_if.rvalid), 32'(e.port == 2));
            chk("a_rdata", 32'(a_if.rdata), (e.port == 1) ? 32'(e.data) : 0);
            chk("b_rdata", 32'(b_if.rdata), (e.port == 2) ? 32'(e.data) : 0);
        end else begin
            chk("idle_a_rvalid", 32'(a_if.rvalid), 0);
            chk("idle_b_rvalid", 32'(b_if.rvalid), 0);
            chk("idle_a_rdata", 32'(a_if.rdata), 0);
            chk("idle_b_rdata", 32'(b_if.rdata), 0);
        end
    end

    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba,
                         input logic [7:0] bd);
        a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
        b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic ga, gb;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Contention: both ports read continuously
        for (int i = 0; i < 18; i++) begin
            step();
            drive(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b0, 8'($urandom), 8'h00);
        end

        // Lone requester B, counter saturation
        for (int i = 0; i < 20; i++) begin
            step();
            drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(i), 8'h00);
        end

        // Write by A, then read back by B
        step(); drive(1'b1, 1'b1, 8'h80, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00);
        step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // Handoff without a bubble
        for (int i = 0; i < 3; i++) begin
            step(); drive(1'b1, 1'b0, 8'(i + 40), 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(); drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(i + 100), 8'h00);
        end

        // Reset while A's read data is still pending
        step(); drive(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b0, 8'($urandom), 8'h00);
        end

        // Random traffic; a requester holds its transaction until granted
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ga = a_if.gnt;
            gb = b_if.gnt;
            step();
            if (!a_if.req || ga) begin
                a_if.req   = ($urandom_range(0, 3) != 0);
                a_if.we    = 1'($urandom_range(0, 1));
                a_if.addr  = 8'($urandom_range(0, 31));
                a_if.wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                a_if.req = 1'b0;
            end
            if (!b_if.req || gb) begin
                b_if.req   = ($urandom_range(0, 3) != 0);
                b_if.we    = 1'($urandom_range(0, 1));
                b_if.addr  = 8'($urandom_range(0, 31));
                b_if.wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                b_if.req = 1'b0;
            end
        end

        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) step();
        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
